hack_cpu_mc: RTL and testbench

Multi-cycle Hack CPU core built around the existing 16-bit `ALU` (zx/nx/zy/ny/f/no, zr/ng). It fetches Hack instructions from an instruction port with a valid handshake and decodes them into ALU controls. It owns the A, D and PC registers, evaluates jumps from `zr`/`ng`, and performs data-memory reads and writes over a simple request/valid port. It is the stage directly upstream of the ALU: it feeds the ALU its operands and control bits and consumes its result and flags.

---
 rtl/hack_pkg.sv | 22 ++
 rtl/ALU.sv | 28 ++
 rtl/hack_cpu_mc.sv | 112 +++++++++++
 tb/tb_hack_cpu_mc.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared definitions for the multi-cycle Hack CPU:
// FSM state encoding and instruction field positions.
package hack_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    MREAD = 2'd1,
    EXEC  = 2'd2
  } state_t;

  localparam int IDX_CTYPE = 15;
  localparam int IDX_A     = 12;
  localparam int CMP_HI    = 11;
  localparam int CMP_LO    = 6;
  localparam int IDX_D1    = 5;
  localparam int IDX_D2    = 4;
  localparam int IDX_D3    = 3;
  localparam int IDX_J1    = 2;
  localparam int IDX_J2    = 1;
  localparam int IDX_J3    = 0;

endpackage

// File: rtl/ALU.sv
// Hack 16-bit ALU: zx/nx/zy/ny/f/no controls,
// zero and negative flags on the result.
module ALU (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng
);

  logic [15:0] x1, x2, y1, y2, o;

  assign x1  = zx ? 16'h0000 : x;
  assign x2  = nx ? ~x1 : x1;
  assign y1  = zy ? 16'h0000 : y;
  assign y2  = ny ? ~y1 : y1;
  assign o   = f ? (x2 + y2) : (x2 & y2);
  assign out = no ? ~o : o;
  assign zr  = (out == 16'h0000);
  assign ng  = out[15];

endmodule

// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU: FETCH / MREAD / EXEC control,
// A/D/PC registers, jump evaluation and memory port.
module hack_cpu_mc (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic [14:0] pc,
  input  logic [15:0] inM,
  input  logic        inM_valid,
  output logic        readM,
  output logic [15:0] outM,
  output logic        writeM,
  output logic [14:0] addressM
);

  import hack_pkg::*;

  state_t      state_q, state_d;
  logic [15:0] a_q, d_q, ir_q, mdr_q;
  logic [14:0] pc_q, pc_inc;
  logic [15:0] alu_y, alu_out;
  logic        zr, ng;
  logic        is_c, jump, in_exec;

  assign is_c    = ir_q[IDX_CTYPE];
  assign alu_y   = ir_q[IDX_A] ? mdr_q : a_q;
  assign pc_inc  = pc_q + 15'd1;
  assign in_exec = ~reset & (state_q == EXEC);

  assign jump = (ir_q[IDX_J1] & ng)
              | (ir_q[IDX_J2] & zr)
              | (ir_q[IDX_J3] & ~ng & ~zr);

  ALU u_alu (
    .x  (d_q),
    .y  (alu_y),
    .zx (ir_q[CMP_HI]),
    .nx (ir_q[CMP_HI-1]),
    .zy (ir_q[CMP_HI-2]),
    .ny (ir_q[CMP_HI-3]),
    .f  (ir_q[CMP_HI-4]),
    .no (ir_q[CMP_LO]),
    .out(alu_out),
    .zr (zr),
    .ng (ng)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH: begin
        if (instr_valid) begin
          if (instr[IDX_CTYPE] & instr[IDX_A])
            state_d = MREAD;
          else
            state_d = EXEC;
        end
      end
      MREAD: begin
        if (inM_valid)
          state_d = EXEC;
      end
      EXEC:    state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // EXEC uses pre-edge A/D/PC, so a jump with A-load targets old A
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      a_q     <= '0;
      d_q     <= '0;
      pc_q    <= '0;
      ir_q    <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        FETCH: begin
          if (instr_valid)
            ir_q <= instr;
        end
        MREAD: begin
          if (inM_valid)
            mdr_q <= inM;
        end
        EXEC: begin
          if (!is_c) begin
            a_q  <= {1'b0, ir_q[14:0]};
            pc_q <= pc_inc;
          end else begin
            if (ir_q[IDX_D1])
              a_q <= alu_out;
            if (ir_q[IDX_D2])
              d_q <= alu_out;
            pc_q <= jump ? a_q[14:0] : pc_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign pc       = pc_q;
  assign addressM = a_q[14:0];
  assign readM    = ~reset & (state_q == MREAD);
  assign writeM   = in_exec & is_c & ir_q[IDX_D3];
  assign outM     = in_exec ? alu_out : 16'h0000;

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Directed bench for hack_cpu_mc: program table plus
// reset-during-read and fetch-stall sequences.
module tb_hack_cpu_mc;

  logic        clock;
  logic        reset;
  logic [15:0] instr;
  logic        instr_valid;
  logic [14:0] pc;
  logic [15:0] inM;
  logic        inM_valid;
  logic        readM;
  logic [15:0] outM;
  logic        writeM;
  logic [14:0] addressM;

  int checks = 0;
  int errors = 0;

  hack_cpu_mc dut (
    .clock      (clock),
    .reset      (reset),
    .instr      (instr),
    .instr_valid(instr_valid),
    .pc         (pc),
    .inM        (inM),
    .inM_valid  (inM_valid),
    .readM      (readM),
    .outM       (outM),
    .writeM     (writeM),
    .addressM   (addressM)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] ins;
    int          wt;
    logic [15:0] m;
    logic [14:0] pc;
    logic [14:0] a;
    int          rd;
    logic        wr;
    logic [14:0] ea;
    logic        chk;
    logic [15:0] out;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic [15:0] ins, input int wt,
    input logic [15:0] m, input logic [14:0] epc,
    input logic [14:0] a, input int rd,
    input logic wr, input logic [14:0] ea,
    input logic chk, input logic [15:0] out);
    vec_t v;
    v.ins = ins; v.wt = wt; v.m = m;
    v.pc = epc; v.a = a; v.rd = rd;
    v.wr = wr; v.ea = ea; v.chk = chk;
    v.out = out;
    return v;
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int idx);
    int rd;
    rd = 0;
    instr = v.ins;
    instr_valid = 1'b1;
    @(posedge clock); #1;
    instr_valid = 1'b0;
    if (readM) begin
      for (int i = 0; i < v.wt; i++) begin
        rd++;
        check($sformatf("v%0d mread addr", idx),
              32'(addressM), 32'(v.ea));
        @(posedge clock); #1;
        if (!readM) break;
      end
      if (readM) begin
        rd++;
        inM = v.m;
        inM_valid = 1'b1;
        @(posedge clock); #1;
        inM_valid = 1'b0;
      end
    end
    check($sformatf("v%0d read cycles", idx),
          32'(rd), 32'(v.rd));
    check($sformatf("v%0d writeM", idx),
          32'(writeM), 32'(v.wr));
    check($sformatf("v%0d exec addr", idx),
          32'(addressM), 32'(v.ea));
    if (v.chk)
      check($sformatf("v%0d outM", idx),
            32'(outM), 32'(v.out));
    @(posedge clock); #1;
    check($sformatf("v%0d writeM after", idx),
          32'(writeM), 32'd0);
    check($sformatf("v%0d pc", idx),
          32'(pc), 32'(v.pc));
    check($sformatf("v%0d A", idx),
          32'(addressM), 32'(v.a));
  endtask

  localparam logic [15:0] PROBE_D = 16'hE300;

  initial begin
    clock = 1'b0;
    reset = 1'b1;
    instr = '0;
    instr_valid = 1'b0;
    inM = '0;
    inM_valid = 1'b0;

    //        ins       wt m        pc        a        rd wr ea       chk out
    vq.push_back(mk(16'h0005, 0, 16'h0, 15'd1, 15'd5, 0, 0, 15'd0, 0, 16'h0));
    vq.push_back(mk(16'hEC10, 0, 16'h0, 15'd2, 15'd5, 0, 0, 15'd5, 1, 16'd5));
    vq.push_back(mk(16'h0064, 0, 16'h0, 15'd3, 15'd100, 0, 0, 15'd5, 0, 16'h0));
    vq.push_back(mk(16'hFC10, 3, 16'd42, 15'd4, 15'd100, 4, 0, 15'd100, 1, 16'd42));
    vq.push_back(mk(PROBE_D, 0, 16'h0, 15'd5, 15'd100, 0, 0, 15'd100, 1, 16'd42));
    vq.push_back(mk(16'h0006, 0, 16'h0, 15'd6, 15'd6, 0, 0, 15'd100, 0, 16'h0));
    vq.push_back(mk(16'hEC10, 0, 16'h0, 15'd7, 15'd6, 0, 0, 15'd6, 1, 16'd6));
    vq.push_back(mk(16'h00C8, 0, 16'h0, 15'd8, 15'd200, 0, 0, 15'd6, 0, 16'h0));
    vq.push_back(mk(16'hE7C8, 0, 16'h0, 15'd9, 15'd200, 0, 1, 15'd200, 1, 16'd7));
    vq.push_back(mk(PROBE_D, 0, 16'h0, 15'd10, 15'd200, 0, 0, 15'd200, 1, 16'd6));
    vq.push_back(mk(16'h0007, 0, 16'h0, 15'd11, 15'd7, 0, 0, 15'd200, 0, 16'h0));
    vq.push_back(mk(16'hEA90, 0, 16'h0, 15'd12, 15'd7, 0, 0, 15'd7, 1, 16'd0));
    vq.push_back(mk(16'hE302, 0, 16'h0, 15'd7, 15'd7, 0, 0, 15'd7, 1, 16'd0));
    vq.push_back(mk(16'hEFD0, 0, 16'h0, 15'd8, 15'd7, 0, 0, 15'd7, 1, 16'd1));
    vq.push_back(mk(16'hE302, 0, 16'h0, 15'd9, 15'd7, 0, 0, 15'd7, 1, 16'd1));
    vq.push_back(mk(16'h000A, 0, 16'h0, 15'd10, 15'd10, 0, 0, 15'd7, 0, 16'h0));
    vq.push_back(mk(16'hECA7, 0, 16'h0, 15'd10, 15'd9, 0, 0, 15'd10, 1, 16'd9));
    vq.push_back(mk(16'hFDD8, 0, 16'hFFFF, 15'd11, 15'd9, 1, 1, 15'd9, 1, 16'd0));
    vq.push_back(mk(16'hEE90, 0, 16'h0, 15'd12, 15'd9, 0, 0, 15'd9, 1, 16'hFFFF));
    vq.push_back(mk(16'hE304, 0, 16'h0, 15'd9, 15'd9, 0, 0, 15'd9, 1, 16'hFFFF));
    vq.push_back(mk(16'hE301, 0, 16'h0, 15'd10, 15'd9, 0, 0, 15'd9, 1, 16'hFFFF));
    vq.push_back(mk(16'h7FFF, 0, 16'h0, 15'd11, 15'h7FFF, 0, 0, 15'd9, 0, 16'h0));
    vq.push_back(mk(16'hEA87, 0, 16'h0, 15'h7FFF, 15'h7FFF, 0, 0, 15'h7FFF, 1, 16'd0));
    vq.push_back(mk(16'hEA90, 0, 16'h0, 15'd0, 15'h7FFF, 0, 0, 15'h7FFF, 1, 16'd0));
    vq.push_back(mk(16'h0003, 0, 16'h0, 15'd1, 15'd3, 0, 0, 15'h7FFF, 0, 16'h0));

    repeat (2) @(posedge clock);
    #1;
    check("reset pc", 32'(pc), 32'd0);
    check("reset addressM", 32'(addressM), 32'd0);
    check("reset readM", 32'(readM), 32'd0);
    check("reset writeM", 32'(writeM), 32'd0);
    check("reset outM", 32'(outM), 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    foreach (vq[i]) run(vq[i], i);

    // Reset arriving while a read is outstanding
    instr = 16'h0064;
    instr_valid = 1'b1;
    @(posedge clock); #1;
    instr_valid = 1'b0;
    @(posedge clock); #1;
    instr = 16'hFC10;
    instr_valid = 1'b1;
    @(posedge clock); #1;
    instr_valid = 1'b0;
    check("mread entry readM", 32'(readM), 32'd1);
    check("mread entry addr", 32'(addressM), 32'd100);
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    check("async reset readM", 32'(readM), 32'd0);
    check("async reset pc", 32'(pc), 32'd0);
    check("async reset A", 32'(addressM), 32'd0);
    check("async reset outM", 32'(outM), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    inM = 16'h1234;
    inM_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      check($sformatf("stall%0d pc", i),
            32'(pc), 32'd0);
      check($sformatf("stall%0d readM", i),
            32'(readM), 32'd0);
      check($sformatf("stall%0d outM", i),
            32'(outM), 32'd0);
    end
    inM_valid = 1'b0;
    run(mk(PROBE_D, 0, 16'h0, 15'd1, 15'd0, 0, 0, 15'd0, 1, 16'd0), 99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
